// File: rtl/fetch_queue.sv
// Fetch stage between the PC register and decode: issues in-order imem requests, buffers returned
// words with their PC, computes the next PC and flushes on redirect.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = CntW + 2;

  logic [31:0]     q_data_q [DEPTH];
  logic [31:0]     q_pc_q   [DEPTH];
  logic [PtrW-1:0] q_rd_q, q_wr_q;
  logic [CntW-1:0] q_cnt_q, q_cnt_d;

  logic [31:0]     if_addr_q [DEPTH];
  logic [PtrW-1:0] if_rd_q, if_wr_q;
  logic [CntW-1:0] if_cnt_q, if_cnt_d;

  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

  logic [SumW-1:0] outstanding;
  logic [SumW-1:0] used;
  logic            req_fire;
  logic            pop;
  logic            rsp_keep;
  logic            rsp_drop;
  logic            unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Dropped requests still hold a credit until their responses come back.
  assign outstanding = SumW'(if_cnt_q) + SumW'(drop_cnt_q);
  assign used        = SumW'(q_cnt_q) + outstanding;

  assign imem_req_valid = !rst && !redirect_valid && (used < SumW'(DEPTH));
  assign imem_req_addr  = pc_cur;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = !rst && (q_cnt_q != '0);
  assign inst_data  = q_data_q[q_rd_q];
  assign inst_pc    = q_pc_q[q_rd_q];
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  assign rsp_drop = imem_rsp_valid && !redirect_valid && (drop_cnt_q != '0);
  assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0) && (if_cnt_q != '0);

  always_comb begin
    pc_next = pc_cur;
    if (rst) begin
      pc_next = RESET_PC;
    end else if (redirect_valid) begin
      pc_next = {redirect_pc[31:2], 2'b00};
    end else if (req_fire) begin
      pc_next = pc_cur + 32'd4;
    end
  end

  always_comb begin
    q_cnt_d    = q_cnt_q;
    if_cnt_d   = if_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      q_cnt_d    = '0;
      if_cnt_d   = '0;
      // A response arriving with the redirect already retires one of the stale requests.
      drop_cnt_d = CntW'(outstanding) - CntW'(imem_rsp_valid && (outstanding != '0));
    end else begin
      q_cnt_d  = q_cnt_q + CntW'(rsp_keep) - CntW'(pop);
      if_cnt_d = if_cnt_q + CntW'(req_fire) - CntW'(rsp_keep);
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      q_cnt_q    <= '0;
      if_rd_q    <= '0;
      if_wr_q    <= '0;
      if_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      q_cnt_q    <= q_cnt_d;
      if_cnt_q   <= if_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      if (redirect_valid) begin
        q_rd_q  <= '0;
        q_wr_q  <= '0;
        if_rd_q <= '0;
        if_wr_q <= '0;
      end else begin
        if (pop)      q_rd_q  <= q_rd_q + PtrW'(1);
        if (rsp_keep) q_wr_q  <= q_wr_q + PtrW'(1);
        if (rsp_keep) if_rd_q <= if_rd_q + PtrW'(1);
        if (req_fire) if_wr_q <= if_wr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      q_data_q[q_wr_q] <= imem_rsp_data;
      q_pc_q[q_wr_q]   <= if_addr_q[if_rd_q];
    end
    if (req_fire) begin
      if_addr_q[if_wr_q] <= pc_cur;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && imem_rsp_valid) begin
      assert (outstanding != '0)
      else $error("fetch_queue: imem response with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle, an in-order imem
// responder, a PC register loop, and directed scenarios with literal expectations.
module tb_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DATA_OFS = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  always #5 clk = ~clk;

  fetch_queue #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_cur        (pc_cur),
    .pc_next       (pc_next),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fires    = 0;
  bit rsp_en   = 1'b1;

  logic [31:0] mem_pend[$];
  logic [31:0] pc_next_s;

  // Reference model: instruction queue of {pc, data}, outstanding addresses, stale responses to drop.
  logic [63:0] m_q[$];
  logic [31:0] m_if[$];
  int          m_drop = 0;

  logic [31:0] got_pc[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] got_pc_at(input int i);
    return (i < got_pc.size()) ? got_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] got_data_at(input int i);
    return (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int got_cyc_at(input int i);
    return (i < got_cyc.size()) ? got_cyc[i] : -100;
  endfunction

  task automatic clear_log();
    got_pc.delete();
    got_data.delete();
    got_cyc.delete();
  endtask

  // Compare DUT outputs with the model, log observations, then advance the model by one edge.
  task automatic compare_and_model();
    logic        exp_req;
    logic        exp_iv;
    logic        fire;
    logic [31:0] exp_pcn;
    logic [63:0] head;
    int          outst;
    exp_req = !rst && !redirect_valid && ((m_q.size() + m_if.size() + m_drop) < int'(DEPTH));
    fire    = exp_req && imem_req_ready;
    if (rst)                 exp_pcn = RESET_PC;
    else if (redirect_valid) exp_pcn = {redirect_pc[31:2], 2'b00};
    else if (fire)           exp_pcn = pc_cur + 32'd4;
    else                     exp_pcn = pc_cur;
    exp_iv = !rst && (m_q.size() > 0);

    check_bit("imem_req_valid", imem_req_valid, exp_req);
    if (exp_req) check("imem_req_addr", imem_req_addr, pc_cur);
    check("pc_next", pc_next, exp_pcn);
    check_bit("inst_valid", inst_valid, exp_iv);
    if (exp_iv) begin
      head = m_q[0];
      check("inst_pc", inst_pc, head[63:32]);
      check("inst_data", inst_data, head[31:0]);
    end

    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      got_pc.push_back(inst_pc);
      got_data.push_back(inst_data);
      got_cyc.push_back(cyc);
    end
    if (imem_req_valid && imem_req_ready) begin
      fires++;
      mem_pend.push_back(imem_req_addr);
    end
    pc_next_s = pc_next;

    if (rst) begin
      m_q.delete();
      m_if.delete();
      m_drop = 0;
      mem_pend.delete();
    end else if (redirect_valid) begin
      outst  = m_if.size() + m_drop;
      m_drop = (imem_rsp_valid && outst > 0) ? outst - 1 : outst;
      m_q.delete();
      m_if.delete();
    end else begin
      if (exp_iv && inst_ready) void'(m_q.pop_front());
      if (imem_rsp_valid) begin
        if (m_drop > 0) m_drop--;
        else if (m_if.size() > 0) m_q.push_back({m_if.pop_front(), imem_rsp_data});
      end
      if (fire) m_if.push_back(pc_cur);
    end
    cyc++;
  endtask

  // PC register and in-order imem with one cycle of latency.
  task automatic drive();
    pc_cur = pc_next_s;
    if (rsp_en && mem_pend.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_pend.pop_front() + DATA_OFS;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    compare_and_model();
    @(posedge clk);
    #1;
    drive();
  endtask

  initial begin
    int gaps;
    rst            = 1'b1;
    pc_cur         = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;

    // T1: reset
    #1;
    check("t1_pc_next_rst", pc_next, 32'h0000_0000);
    check_bit("t1_req_valid_rst", imem_req_valid, 1'b0);
    repeat (2) cycle();
    rst = 1'b0;
    #1;
    check_bit("t1_req_valid", imem_req_valid, 1'b1);
    check("t1_req_addr", imem_req_addr, 32'h0000_0000);
    check_bit("t1_inst_valid", inst_valid, 1'b0);

    // T2: streaming
    inst_ready = 1'b1;
    clear_log();
    repeat (14) cycle();
    for (int k = 0; k < 8; k++) begin
      check("t2_pc", got_pc_at(k), 32'(4 * k));
      check("t2_data", got_data_at(k), 32'(4 * k) + DATA_OFS);
    end
    gaps = 0;
    for (int k = 2; k < 7; k++) if (got_cyc_at(k + 1) - got_cyc_at(k) != 1) gaps++;
    check("t2_rate_gaps", 32'(gaps), 32'd0);

    // T3: backpressure from a fresh redirect target
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    clear_log();
    cycle();
    redirect_valid = 1'b0;
    fires          = 0;
    repeat (12) cycle();
    #1;
    check("t3_fires", 32'(fires), DEPTH);
    check_bit("t3_req_valid", imem_req_valid, 1'b0);
    check("t3_pc_hold", pc_next, 32'h0000_0210);
    check_bit("t3_inst_valid", inst_valid, 1'b1);
    check("t3_inst_pc", inst_pc, 32'h0000_0200);
    inst_ready = 1'b1;
    clear_log();
    repeat (10) cycle();
    for (int k = 0; k < 6; k++) begin
      check("t3_resume_pc", got_pc_at(k), 32'h0000_0200 + 32'(4 * k));
    end

    // T4: redirect with exactly two requests in flight
    imem_req_ready = 1'b0;
    repeat (6) cycle();
    rsp_en         = 1'b0;
    imem_req_ready = 1'b1;
    repeat (2) cycle();
    imem_req_ready = 1'b0;
    clear_log();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    cycle();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    rsp_en         = 1'b1;
    #1;
    check_bit("t4_req_valid", imem_req_valid, 1'b1);
    check("t4_req_addr", imem_req_addr, 32'h0000_0100);
    repeat (8) cycle();
    check("t4_first_pc", got_pc_at(0), 32'h0000_0100);
    check("t4_first_data", got_data_at(0), 32'h1000_0100);
    check("t4_second_pc", got_pc_at(1), 32'h0000_0104);

    // T5: redirect together with pop and response
    repeat (4) cycle();
    #1;
    check_bit("t5_pre_inst_valid", inst_valid, 1'b1);
    check_bit("t5_pre_rsp_valid", imem_rsp_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    clear_log();
    cycle();
    redirect_valid = 1'b0;
    #1;
    check_bit("t5_inst_valid_after", inst_valid, 1'b0);
    repeat (8) cycle();
    check("t5_first_pc", got_pc_at(0), 32'h0000_0400);
    check_bit("t5_no_pop_logged", got_cyc_at(0) > 0, 1'b1);

    // T6: address wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    clear_log();
    cycle();
    redirect_valid = 1'b0;
    #1;
    check_bit("t6_req_valid", imem_req_valid, 1'b1);
    check("t6_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    check("t6_pc_next", pc_next, 32'h0000_0000);
    repeat (8) cycle();
    check("t6_first_pc", got_pc_at(0), 32'hFFFF_FFFC);
    check("t6_first_data", got_data_at(0), 32'h0FFF_FFFC);
    check("t6_second_pc", got_pc_at(1), 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
